// File: rtl/mod_n_divider_pkg.sv
// -----------------------------------------------------------------------------
// mod_n_divider_pkg
// Shared constants for the mod-N divider and its 4-bit counter slices.
//   CNT_W    : full count width
//   SLICE_W  : width of one ctr4_slice
//   RST_CNT  : count value forced while RESET_L is low
//   slice_rst: reset value of one slice, taken from RST_CNT
// -----------------------------------------------------------------------------
package mod_n_divider_pkg;

    localparam int CNT_W   = 8;
    localparam int SLICE_W = 4;
    localparam int N_SLICE = CNT_W / SLICE_W;

    localparam logic [CNT_W-1:0] RST_CNT = 8'h00;

    function automatic logic [SLICE_W-1:0] slice_rst(input int idx);
        return RST_CNT[idx*SLICE_W +: SLICE_W];
    endfunction

endpackage

// File: rtl/mod_n_divider_ctr4_slice.sv
// -----------------------------------------------------------------------------
// ctr4_slice
// 4-bit synchronous counter slice, cascadable through rco.
// Per-edge priority: clear, then load, then count (enp & ent), else hold.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, q -> RST_VAL
//   clr_l  : synchronous clear, active low
//   ld_l   : synchronous parallel load, active low
//   d      : load value
//   enp    : count enable (not propagated to rco)
//   ent    : count enable, also gates rco
//   q      : registered count
//   rco    : combinational carry, ent & (q == all ones)
// -----------------------------------------------------------------------------
module ctr4_slice
    import mod_n_divider_pkg::*;
#(
    parameter logic [SLICE_W-1:0] RST_VAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_l,
    input  logic               ld_l,
    input  logic [SLICE_W-1:0] d,
    input  logic               enp,
    input  logic               ent,
    output logic [SLICE_W-1:0] q,
    output logic               rco
);

    localparam logic [SLICE_W-1:0] ONE = {{(SLICE_W-1){1'b0}}, 1'b1};

    logic [SLICE_W-1:0] q_q;
    logic [SLICE_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (!clr_l) begin
            q_d = '0;
        end else if (!ld_l) begin
            q_d = d;
        end else if (enp && ent) begin
            q_d = q_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q   = q_q;
    assign rco = ent & (&q_q);

endmodule

// File: rtl/mod_n_divider.sv
// -----------------------------------------------------------------------------
// mod_n_divider
// Programmable modulo-(MODN+1) counter built from two ctr4_slice instances,
// with a registered terminal-count pulse and an optional divided square wave.
//
// Build option:
//   MOD_N_DIVIDER_DIVOUT_EN : when defined, DIVOUT is a flop that toggles at
//                             every wrap edge; otherwise DIVOUT is tied to 0.
//
// Ports:
//   CLK     : clock, rising edge
//   RESET_L : asynchronous active-low reset (Q=0, TC=0, DIVOUT=0)
//   CLR_L   : synchronous clear, active low (highest priority)
//   LD_L    : synchronous parallel load of D, active low
//   D       : parallel load value
//   ENP,ENT : count enables, both high to count
//   MODN    : terminal count, the counter runs 0..MODN
//   Q       : registered count
//   RCO     : combinational cascade carry, ENT & (Q == 8'hFF)
//   TC      : registered one-cycle pulse following each wrap edge
//   DIVOUT  : registered divided square wave, period 2*(MODN+1)
// -----------------------------------------------------------------------------
module mod_n_divider
    import mod_n_divider_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             CLR_L,
    input  logic             LD_L,
    input  logic [CNT_W-1:0] D,
    input  logic             ENP,
    input  logic             ENT,
    input  logic [CNT_W-1:0] MODN,
    output logic [CNT_W-1:0] Q,
    output logic             RCO,
    output logic             TC,
    output logic             DIVOUT
);

    logic [SLICE_W-1:0] lo_q;
    logic [SLICE_W-1:0] hi_q;
    logic               lo_rco;
    logic               hi_rco;
    logic [CNT_W-1:0]   cnt;

    logic count_en;
    logic wrap;
    logic slice_clr_l;

    logic tc_q;
    logic tc_d;

    assign cnt = {hi_q, lo_q};

    // A wrap is an ordinary counting edge that lands on MODN; it is turned
    // into a synchronous clear of both slices. Clear and load take priority,
    // so they never count as a wrap. Counting past 8'hFF with MODN != 8'hFF
    // rolls over naturally inside the slices and is not a wrap.
    always_comb begin
        count_en    = CLR_L & LD_L & ENP & ENT;
        wrap        = count_en & (cnt == MODN);
        slice_clr_l = CLR_L & ~wrap;
    end

    ctr4_slice #(
        .RST_VAL (slice_rst(0))
    ) u_slice_lo (
        .clk   (CLK),
        .rst_n (RESET_L),
        .clr_l (slice_clr_l),
        .ld_l  (LD_L),
        .d     (D[SLICE_W-1:0]),
        .enp   (ENP),
        .ent   (ENT),
        .q     (lo_q),
        .rco   (lo_rco)
    );

    // The high slice only advances when the low slice carries.
    ctr4_slice #(
        .RST_VAL (slice_rst(1))
    ) u_slice_hi (
        .clk   (CLK),
        .rst_n (RESET_L),
        .clr_l (slice_clr_l),
        .ld_l  (LD_L),
        .d     (D[CNT_W-1:SLICE_W]),
        .enp   (ENP),
        .ent   (lo_rco),
        .q     (hi_q),
        .rco   (hi_rco)
    );

    // hi_rco already equals ENT & (low nibble all ones) & (high nibble all ones).
    assign RCO = hi_rco;
    assign Q   = cnt;

    always_comb begin
        tc_d = wrap;
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            tc_q <= 1'b0;
        end else begin
            tc_q <= tc_d;
        end
    end

    assign TC = tc_q;

`ifdef MOD_N_DIVIDER_DIVOUT_EN
    logic divout_q;
    logic divout_d;

    always_comb begin
        divout_d = divout_q ^ wrap;
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            divout_q <= 1'b0;
        end else begin
            divout_q <= divout_d;
        end
    end

    assign DIVOUT = divout_q;
`else
    assign DIVOUT = 1'b0;
`endif

endmodule

// File: tb/tb_mod_n_divider.sv
// -----------------------------------------------------------------------------
// tb_mod_n_divider
// Directed vectors for mod_n_divider. The driver applies one vector per clock
// on the falling edge and queues the hand-computed outputs expected after the
// following rising edge; the monitor pops and compares after each rising edge
// (and after an asynchronous reset assertion).
// DIVOUT expectations collapse to 0 when MOD_N_DIVIDER_DIVOUT_EN is undefined.
// -----------------------------------------------------------------------------
module tb_mod_n_divider;

`ifdef MOD_N_DIVIDER_DIVOUT_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic       CLK;
    logic       RESET_L;
    logic       CLR_L;
    logic       LD_L;
    logic [7:0] D;
    logic       ENP;
    logic       ENT;
    logic [7:0] MODN;
    logic [7:0] Q;
    logic       RCO;
    logic       TC;
    logic       DIVOUT;

    typedef struct {
        logic [7:0] q;
        logic       tc;
        logic       dv;
        logic       rco;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    mod_n_divider dut (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .CLR_L   (CLR_L),
        .LD_L    (LD_L),
        .D       (D),
        .ENP     (ENP),
        .ENT     (ENT),
        .MODN    (MODN),
        .Q       (Q),
        .RCO     (RCO),
        .TC      (TC),
        .DIVOUT  (DIVOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] eq, input logic etc, input logic edv,
                            input logic erco);
        exp_t e;
        e.q   = eq;
        e.tc  = etc;
        e.dv  = DIV_EN ? edv : 1'b0;
        e.rco = erco;
        sb.push_back(e);
    endtask

    task automatic apply(input logic clr, input logic ld, input logic [7:0] d,
                         input logic enp, input logic ent, input logic [7:0] modn,
                         input logic [7:0] eq, input logic etc, input logic edv,
                         input logic erco);
        @(negedge CLK);
        CLR_L = clr;
        LD_L  = ld;
        D     = d;
        ENP   = enp;
        ENT   = ent;
        MODN  = modn;
        push_exp(eq, etc, edv, erco);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK or negedge RESET_L);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("q",      Q,            e.q);
                chk("tc",     {7'd0, TC},     {7'd0, e.tc});
                chk("divout", {7'd0, DIVOUT}, {7'd0, e.dv});
                chk("rco",    {7'd0, RCO},    {7'd0, e.rco});
            end
        end
    end

    // Driver
    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        RESET_L = 1'b0;
        CLR_L   = 1'b1;
        LD_L    = 1'b1;
        D       = 8'h00;
        ENP     = 1'b0;
        ENT     = 1'b0;
        MODN    = 8'h00;

        // Reset held across an edge with counting requested: outputs stay 0.
        apply(1, 1, 8'h00, 1, 1, 8'd5, 8'h00, 0, 0, 0);
        @(negedge CLK);
        ENP     = 1'b0;
        RESET_L = 1'b1;

        // MODN=5 continuous count, 12 edges.
        apply(1, 1, 8'h00, 1, 1, 8'd5, 8'd1, 0, 0, 0);
        apply(1, 1, 8'h00, 1, 1, 8'd5, 8'd2, 0, 0, 0);
        apply(1, 1, 8'h00, 1, 1, 8'd5, 8'd3, 0, 0, 0);
        apply(1, 1, 8'h00, 1, 1, 8'd5, 8'd4, 0, 0, 0);
        apply(1, 1, 8'h00, 1, 1, 8'd5, 8'd5, 0, 0, 0);
        apply(1, 1, 8'h00, 1, 1, 8'd5, 8'd0, 1, 1, 0);
        apply(1, 1, 8'h00, 1, 1, 8'd5, 8'd1, 0, 1, 0);
        apply(1, 1, 8'h00, 1, 1, 8'd5, 8'd2, 0, 1, 0);
        apply(1, 1, 8'h00, 1, 1, 8'd5, 8'd3, 0, 1, 0);
        apply(1, 1, 8'h00, 1, 1, 8'd5, 8'd4, 0, 1, 0);
        apply(1, 1, 8'h00, 1, 1, 8'd5, 8'd5, 0, 1, 0);
        apply(1, 1, 8'h00, 1, 1, 8'd5, 8'd0, 1, 0, 0);

        // Count to 3, then clear beats load, then load alone, then hold.
        apply(1, 1, 8'h00, 1, 1, 8'd5, 8'd1, 0, 0, 0);
        apply(1, 1, 8'h00, 1, 1, 8'd5, 8'd2, 0, 0, 0);
        apply(1, 1, 8'h00, 1, 1, 8'd5, 8'd3, 0, 0, 0);
        apply(0, 0, 8'h07, 1, 1, 8'd5, 8'd0, 0, 0, 0);
        apply(1, 0, 8'h07, 1, 1, 8'd5, 8'h07, 0, 0, 0);
        apply(1, 1, 8'h00, 0, 1, 8'd5, 8'h07, 0, 0, 0);

        // MODN=0: Q stays 0, TC high every counting cycle, DIVOUT toggles each edge.
        apply(0, 1, 8'h00, 1, 1, 8'd0, 8'd0, 0, 0, 0);
        apply(1, 1, 8'h00, 1, 1, 8'd0, 8'd0, 1, 1, 0);
        apply(1, 1, 8'h00, 1, 1, 8'd0, 8'd0, 1, 0, 0);
        apply(1, 1, 8'h00, 1, 1, 8'd0, 8'd0, 1, 1, 0);
        apply(1, 1, 8'h00, 0, 1, 8'd0, 8'd0, 0, 1, 0);

        // MODN=8'hFF: load FE, RCO at FF, wrap with TC; RCO gated by ENT.
        apply(1, 0, 8'hFE, 1, 1, 8'hFF, 8'hFE, 0, 1, 0);
        apply(1, 1, 8'h00, 1, 1, 8'hFF, 8'hFF, 0, 1, 1);
        apply(1, 1, 8'h00, 1, 1, 8'hFF, 8'h00, 1, 0, 0);
        apply(1, 0, 8'hFF, 1, 0, 8'hFF, 8'hFF, 0, 0, 0);
        apply(1, 1, 8'h00, 0, 1, 8'hFF, 8'hFF, 0, 0, 1);
        apply(1, 1, 8'h00, 0, 0, 8'hFF, 8'hFF, 0, 0, 0);

        // MODN=8'h10 loaded above it: roll over at FF without TC, then wrap at 10.
        apply(1, 0, 8'h20, 1, 1, 8'h10, 8'h20, 0, 0, 0);
        for (int v = 8'h21; v <= 8'hFF; v++) begin
            apply(1, 1, 8'h00, 1, 1, 8'h10, 8'(v), 0, 0, (v == 8'hFF));
        end
        apply(1, 1, 8'h00, 1, 1, 8'h10, 8'h00, 0, 0, 0);
        for (int v = 1; v <= 8'h10; v++) begin
            apply(1, 1, 8'h00, 1, 1, 8'h10, 8'(v), 0, 0, 0);
        end
        apply(1, 1, 8'h00, 1, 1, 8'h10, 8'h00, 1, 1, 0);
        apply(1, 1, 8'h00, 1, 1, 8'h10, 8'h01, 0, 1, 0);

        // Clear keeps DIVOUT, count to 9, then asynchronous reset mid-cycle.
        apply(0, 1, 8'h00, 1, 1, 8'h14, 8'h00, 0, 1, 0);
        for (int v = 1; v <= 9; v++) begin
            apply(1, 1, 8'h00, 1, 1, 8'h14, 8'(v), 0, 1, 0);
        end
        @(negedge CLK);
        push_exp(8'h00, 0, 0, 0);
        #2;
        RESET_L = 1'b0;
        @(negedge CLK);
        RESET_L = 1'b1;
        push_exp(8'h01, 0, 0, 0);
        apply(1, 1, 8'h00, 1, 1, 8'h14, 8'h02, 0, 0, 0);

        for (int i = 0; i < 5 && sb.size() != 0; i++) begin
            @(posedge CLK);
        end
        #2;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries never compared", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod_n_divider.md
MOD_N_DIVIDER -- requirements
Module: mod_n_divider

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port RESET_L, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port CLR_L, input, 1 bit: synchronous clear, active low.
REQ-004 SHALL have port LD_L, input, 1 bit: synchronous parallel load, active low.
REQ-005 SHALL have port D, input, 8 bits: parallel load value.
REQ-006 SHALL have ports ENP and ENT, input, 1 bit each: count enables; counting requires both high.
REQ-007 SHALL have port MODN, input, 8 bits: terminal count; the divider counts 0..MODN.
REQ-008 SHALL have port Q, output, 8 bits: registered count value.
REQ-009 SHALL have port RCO, output, 1 bit: cascade carry, combinational, high when ENT=1 and Q=8'hFF.
REQ-010 SHALL have port TC, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-011 SHALL have port DIVOUT, output, 1 bit: registered divided square wave.

Function
REQ-012 SHALL apply per-edge priority CLR_L low, then LD_L low, then count (ENP&ENT), else hold.
REQ-013 SHALL set Q=0 on an edge with CLR_L=0, regardless of LD_L, ENP, ENT.
REQ-014 SHALL set Q=D on an edge with CLR_L=1 and LD_L=0, regardless of enables.
REQ-015 SHALL, when counting and Q==MODN, load Q=0 at that edge (wrap), else Q=Q+1.
REQ-016 SHALL, when counting, Q=8'hFF, and Q!=MODN, wrap Q to 0 with no TC and no DIVOUT toggle.
REQ-017 SHALL compare Q against the live MODN value each cycle; a MODN change takes effect at the next edge.
REQ-018 SHALL assert TC for exactly the one cycle following a wrap edge (REQ-015); TC is 0 otherwise, including after clear or load.
REQ-019 SHALL, with MODN=0 and continuous counting, hold Q=0 and keep TC high every cycle.
REQ-020 SHALL toggle DIVOUT at every wrap edge, giving period 2*(MODN+1) CLK cycles under continuous enable.
REQ-021 SHALL leave DIVOUT unchanged on clear, load and hold.
REQ-022 SHALL force RCO=0 whenever ENT=0, independent of Q.

Reset
REQ-023 SHALL, while RESET_L=0, force Q=8'h00, TC=0, DIVOUT=0 immediately, without a clock edge.
REQ-024 SHALL, on RESET_L deassertion, resume REQ-012 behaviour from the first rising CLK edge; reset mid-count discards the count.

Configuration
REQ-025 SHALL, with macro MOD_N_DIVIDER_DIVOUT_EN defined, implement the DIVOUT toggle flop per REQ-020/021.
REQ-026 SHALL, without MOD_N_DIVIDER_DIVOUT_EN, tie DIVOUT to constant 0 and omit its flop; all other behaviour unchanged.

Structure
REQ-027 SHALL place constants CNT_W=8, SLICE_W=4, and the reset count value 8'h00 in shared package mod_n_divider_pkg.
REQ-028 SHALL build the count from two instances of sub-module ctr4_slice (4-bit synchronous clear/load/ENP/ENT counter with RCO), the low slice's RCO driving the high slice's ENT.
REQ-029 SHALL implement wrap detect, TC and DIVOUT in mod_n_divider, outside the slices.

Verification
REQ-030 Reset, then MODN=5, ENP=ENT=1, 12 edges -> Q sequence 1,2,3,4,5,0,1,2,3,4,5,0; TC high in the cycles after Q goes 5->0; DIVOUT toggles twice.
REQ-031 Q=3 counting, LD_L=0 with CLR_L=0, D=8'h7 -> Q=0 next edge; then LD_L=0 only -> Q=8'h07; TC stays 0.
REQ-032 MODN=8'hFF, D=8'hFE loaded, ENT=1 -> RCO=1 while Q=8'hFF; next counting edge Q=0, TC=1; ENT=0 -> RCO=0.
REQ-033 MODN=8'h10, D=8'h20 loaded, count -> Q runs 8'h20..8'hFF, wraps to 0 with TC=0, then TC pulses after Q=8'h10.
REQ-034 RESET_L=0 asynchronously mid-count at Q=8'h09 -> Q=0, TC=0, DIVOUT=0 before next CLK edge; resumes at Q=1.
REQ-035 Build without MOD_N_DIVIDER_DIVOUT_EN, rerun REQ-030 -> identical Q and TC, DIVOUT constantly 0.
